// File: rtl/asymmetric_fifo.sv
// Width-converting FIFO: wide words in, narrow slices out (slice 0 first),
// built on a distributed RAM with one wide write port and one narrow read port.

module asymmetric_distributed_ram #(
    parameter int WIDTH_IN  = 64,
    parameter int WIDTH_OUT = 8,
    parameter int DEPTH_IN  = 32
) (
    input  logic                                            clk,
    input  logic                                            we,
    input  logic [$clog2(DEPTH_IN)-1:0]                     addr_a,
    input  logic [WIDTH_IN-1:0]                             din,
    input  logic [$clog2(DEPTH_IN*(WIDTH_IN/WIDTH_OUT))-1:0] addr_b,
    output logic [WIDTH_OUT-1:0]                            dout
);
    localparam int RATIO      = WIDTH_IN / WIDTH_OUT;
    localparam int LOG2_RATIO = $clog2(RATIO);
    localparam int DEPTH_OUT  = DEPTH_IN * RATIO;
    localparam int BW         = $clog2(DEPTH_OUT);

    logic [WIDTH_OUT-1:0] mem [DEPTH_OUT];
    logic [BW-1:0]        base;

    // Slice k of a wide word lands at narrow address {addr_a, k}.
    assign base = BW'(addr_a) << LOG2_RATIO;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < RATIO; k++) begin
                mem[base + BW'(k)] <= din[k*WIDTH_OUT +: WIDTH_OUT];
            end
        end
    end

    assign dout = mem[addr_b];
endmodule

module asymmetric_fifo #(
    parameter int WIDTH_IN  = 64,
    parameter int WIDTH_OUT = 8,
    parameter int DEPTH_IN  = 32
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          clear,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [WIDTH_IN-1:0]                           in,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [WIDTH_OUT-1:0]                          out,
    output logic [$clog2(DEPTH_IN*(WIDTH_IN/WIDTH_OUT)):0] level
);
    localparam int RATIO      = WIDTH_IN / WIDTH_OUT;
    localparam int LOG2_RATIO = $clog2(RATIO);
    localparam int DEPTH_OUT  = DEPTH_IN * RATIO;
    localparam int AW         = $clog2(DEPTH_IN);
    localparam int BW         = $clog2(DEPTH_OUT);

    logic [AW:0]          wr_ptr;
    logic [BW:0]          rd_ptr;
    logic                 we;
    logic                 fetch;
    logic [WIDTH_OUT-1:0] ram_dout;

    // Occupancy in narrow units; the wrap bits keep full and empty distinct.
    assign level    = ((BW+1)'(wr_ptr) << LOG2_RATIO) - rd_ptr;
    assign in_ready = (level <= (BW+1)'(DEPTH_OUT - RATIO));
    assign we       = in_valid && in_ready && !clear;
    assign fetch    = (level != '0) && (!out_valid || out_ready);

    asymmetric_distributed_ram #(
        .WIDTH_IN (WIDTH_IN),
        .WIDTH_OUT(WIDTH_OUT),
        .DEPTH_IN (DEPTH_IN)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .addr_a(wr_ptr[AW-1:0]),
        .din   (in),
        .addr_b(rd_ptr[BW-1:0]),
        .dout  (ram_dout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out       <= '0;
        end else if (clear) begin
            // Flush leaves the RAM and the stale out register untouched.
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
        end else begin
            if (we) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (fetch) begin
                out       <= ram_dout;
                out_valid <= 1'b1;
                rd_ptr    <= rd_ptr + (BW+1)'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_asymmetric_fifo.sv
// Randomized bench for asymmetric_fifo against a byte-queue reference model,
// plus literal checks on reset, latency, full/empty and flush behaviour.

module tb_asymmetric_fifo;
    localparam int WI = 64;
    localparam int WO = 8;
    localparam int DI = 32;
    localparam int RATIO = WI / WO;
    localparam int DO = DI * RATIO;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [WI-1:0] din;
    logic          out_valid;
    logic          out_ready;
    logic [WO-1:0] dout;
    logic [8:0]    level;

    int total = 0;
    int bad   = 0;

    asymmetric_fifo #(.WIDTH_IN(WI), .WIDTH_OUT(WO), .DEPTH_IN(DI)) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in       (din),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (dout),
        .level    (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: slices held in RAM as a plain queue, plus the output register.
    logic [WO-1:0] q[$];
    logic          m_valid;
    logic [WO-1:0] m_out;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_valid = 1'b0;
            m_out   = '0;
        end else begin
            int  ml;
            bit  f;
            bit  acc;
            ml  = q.size();
            f   = (ml != 0) && (!m_valid || out_ready);
            acc = in_valid && (ml <= DO - RATIO);
            if (clear) begin
                q.delete();
                m_valid = 1'b0;
            end else begin
                if (f) begin
                    m_out   = q.pop_front();
                    m_valid = 1'b1;
                end else if (out_ready) begin
                    m_valid = 1'b0;
                end
                if (acc) begin
                    for (int k = 0; k < RATIO; k++) q.push_back(din[k*WO +: WO]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            int ml;
            ml = q.size();
            chk("level", int'(level), ml);
            chk("in_ready", int'(in_ready), int'(ml <= DO - RATIO));
            chk("out_valid", int'(out_valid), int'(m_valid));
            if (m_valid) chk("out", int'(dout), int'(m_out));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((level != 0 || out_valid) && g < 600) begin
            step();
            g++;
        end
        chk("drain_bound", int'(g < 600), 1);
    endtask

    // Leaves the RAM empty while the output register holds a slice.
    task automatic prime_hold();
        int g;
        din       = {$urandom, $urandom};
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        g = 0;
        while (!(level == 0 && out_valid) && g < 50) begin
            step();
            g++;
        end
        out_ready = 1'b0;
        chk("prime_bound", int'(g < 50), 1);
    endtask

    initial begin
        int cnt;
        int g;
        bit acc;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0;
        step(2);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_out", int'(dout), 0);
        rst = 1'b0;
        step(3);
        chk("idle_in_ready", int'(in_ready), 1);
        chk("idle_level", int'(level), 0);

        // Single word: two-cycle latency then eight consecutive bytes.
        din = 64'h0807060504030201;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("lat_c1_valid", int'(out_valid), 0);
        chk("lat_c1_level", int'(level), 8);
        step();
        for (int b = 1; b <= 8; b++) begin
            chk("seq_valid", int'(out_valid), 1);
            chk("seq_byte", int'(dout), b);
            step();
        end
        chk("after_seq_valid", int'(out_valid), 0);
        chk("after_seq_level", int'(level), 0);

        // Fill to full behind a held output slice.
        drain();
        prime_hold();
        in_valid = 1'b1;
        for (int w = 0; w < DI; w++) begin
            din = {$urandom, $urandom};
            step();
        end
        in_valid = 1'b0;
        chk("full_level", int'(level), 256);
        chk("full_in_ready", int'(in_ready), 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pulse_level", int'(level), 255);
        chk("pulse_in_ready", int'(in_ready), 0);
        out_ready = 1'b1;
        step(6);
        chk("r6_in_ready", int'(in_ready), 0);
        step();
        chk("r7_in_ready", int'(in_ready), 1);
        chk("r7_level", int'(level), 248);

        // Concurrent write and drain across several pointer wraps.
        in_valid = 1'b1;
        cnt = 0;
        g = 0;
        while (cnt < 100 && g < 5000) begin
            for (int b = 0; b < RATIO; b++) din[b*WO +: WO] = 8'((cnt * RATIO + b) & 255);
            acc = in_ready;
            step();
            if (acc) cnt++;
            g++;
        end
        chk("stream_bound", int'(g < 5000), 1);
        in_valid = 1'b0;
        drain();

        // Random traffic with backpressure and occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            din       = {$urandom, $urandom};
            clear     = ($urandom_range(0, 99) == 0);
            step();
        end
        clear = 1'b0;
        drain();

        // Flush with data buffered, the output valid and a write presented.
        prime_hold();
        in_valid = 1'b1;
        for (int w = 0; w < 5; w++) begin
            din = {$urandom, $urandom};
            step();
        end
        chk("pre_clear_level", int'(level), 40);
        chk("pre_clear_valid", int'(out_valid), 1);
        clear = 1'b1;
        din = 64'hDEADBEEFCAFEF00D;
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clear_level", int'(level), 0);
        chk("clear_valid", int'(out_valid), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("post_clear_valid", int'(out_valid), 0);
        end

        // Asynchronous reset mid-cycle with data buffered.
        in_valid = 1'b1;
        out_ready = 1'b0;
        din = {$urandom, $urandom};
        step(3);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_level", int'(level), 0);
        chk("arst_out", int'(dout), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(3);
        chk("post_arst_level", int'(level), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
